// File: rtl/legv8_pkg.sv
// Shared LEGv8 ALU-interface definitions: opcode patterns, ALU control codes,
// issue-controller state encoding and the decoder result record.
package legv8_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_ORR   = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_PASSB = 4'd7;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_MOVZ = 11'b11010010100;

  // Mask bits set to 1 are significant; the low bits of CBZ/B/MOVZ carry operand fields.
  localparam logic [10:0] MSK_FULL = 11'b11111111111;
  localparam logic [10:0] MSK_CBZ  = 11'b11111111000;
  localparam logic [10:0] MSK_B    = 11'b11111100000;
  localparam logic [10:0] MSK_MOVZ = 11'b11111111100;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       use_imm;
    logic       is_cbz;
    logic       is_b;
    logic       illegal;
  } dec_t;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                    input logic [10:0] msk);
    return (op & msk) == (pat & msk);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: maps instruction bits [31:21] to ALU control
// code, operand-B source and branch-type flags.
module alu_ctrl_decode
  import legv8_pkg::*;
(
  input  logic [10:0] i_opcode,
  output dec_t        o_dec
);

  always_comb begin
    o_dec = '{alu_ctrl: ALU_AND, use_imm: 1'b0, is_cbz: 1'b0, is_b: 1'b0, illegal: 1'b0};
    if (op_match(i_opcode, OP_ADD, MSK_FULL))
      o_dec.alu_ctrl = ALU_ADD;
    else if (op_match(i_opcode, OP_SUB, MSK_FULL))
      o_dec.alu_ctrl = ALU_SUB;
    else if (op_match(i_opcode, OP_AND, MSK_FULL))
      o_dec.alu_ctrl = ALU_AND;
    else if (op_match(i_opcode, OP_ORR, MSK_FULL))
      o_dec.alu_ctrl = ALU_ORR;
    else if (op_match(i_opcode, OP_LDUR, MSK_FULL) || op_match(i_opcode, OP_STUR, MSK_FULL)) begin
      o_dec.alu_ctrl = ALU_ADD;
      o_dec.use_imm  = 1'b1;
    end else if (op_match(i_opcode, OP_CBZ, MSK_CBZ)) begin
      o_dec.alu_ctrl = ALU_PASSB;
      o_dec.is_cbz   = 1'b1;
    end else if (op_match(i_opcode, OP_B, MSK_B)) begin
      o_dec.alu_ctrl = ALU_PASSB;
      o_dec.use_imm  = 1'b1;
      o_dec.is_b     = 1'b1;
    end else if (op_match(i_opcode, OP_MOVZ, MSK_MOVZ)) begin
      o_dec.alu_ctrl = ALU_PASSB;
      o_dec.use_imm  = 1'b1;
    end else
      o_dec.illegal  = 1'b1;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/collect controller in front of the ALU: registers operands, waits out
// the ALU settle window, captures BusW/Zero and hands the result downstream.
module alu_issue_ctrl
  import legv8_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        ResetL,
  input  logic        InValid,
  output logic        InReady,
  input  logic [10:0] Opcode,
  input  logic [63:0] RegA,
  input  logic [63:0] RegB,
  input  logic [63:0] Imm,
  output logic [63:0] BusA,
  output logic [63:0] BusB,
  output logic [3:0]  ALUCtrl,
  input  logic [63:0] BusW,
  input  logic        Zero,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [63:0] Result,
  output logic        ZeroOut,
  output logic        BranchTaken,
  output logic        IllegalOp
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_bus_a, r_bus_b, r_result;
  logic [3:0]  r_alu_ctrl;
  logic        r_zero, r_taken, r_illegal, r_out_valid;
  logic        r_is_cbz, r_is_b, r_pend_ill;
  dec_t        w_dec;
  logic        w_accept;

  alu_ctrl_decode u_dec (
    .i_opcode (Opcode),
    .o_dec    (w_dec)
  );

  assign InReady  = (r_state == IDLE) && ResetL;
  assign w_accept = InValid && InReady;

  always_ff @(posedge CLK) begin
    if (!ResetL) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bus_a     <= '0;
      r_bus_b     <= '0;
      r_alu_ctrl  <= ALU_AND;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      r_is_cbz    <= 1'b0;
      r_is_b      <= 1'b0;
      r_pend_ill  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= SETTLE;
          if (w_dec.illegal) begin
            // Flags are final at accept; one SETTLE cycle aligns OutValid to k+1.
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_taken    <= 1'b0;
            r_illegal  <= 1'b1;
            r_pend_ill <= 1'b1;
            r_cnt      <= 4'd1;
          end else begin
            r_bus_a    <= RegA;
            r_bus_b    <= w_dec.use_imm ? Imm : RegB;
            r_alu_ctrl <= w_dec.alu_ctrl;
            r_is_cbz   <= w_dec.is_cbz;
            r_is_b     <= w_dec.is_b;
            r_pend_ill <= 1'b0;
            r_cnt      <= SETTLE_LD;
          end
        end
        SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (!r_pend_ill) begin
              r_result  <= BusW;
              r_zero    <= Zero;
              r_taken   <= (r_is_cbz && Zero) || r_is_b;
              r_illegal <= 1'b0;
            end
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end
        end
        HOLD: if (OutReady) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BusA        = r_bus_a;
  assign BusB        = r_bus_b;
  assign ALUCtrl     = r_alu_ctrl;
  assign OutValid    = r_out_valid;
  assign Result      = r_result;
  assign ZeroOut     = r_zero;
  assign BranchTaken = r_taken;
  assign IllegalOp   = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the bus side, table vectors,
// hand-written stall/reset sequences and randomized ops against a reference model.
module tb_alu_issue_ctrl;

  localparam int S = 2;

  logic        CLK = 1'b0;
  logic        ResetL, InValid, InReady, OutValid, OutReady;
  logic [10:0] Opcode;
  logic [63:0] RegA, RegB, Imm, BusA, BusB, BusW, Result;
  logic [3:0]  ALUCtrl;
  logic        Zero, ZeroOut, BranchTaken, IllegalOp;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_busa, exp_busb;
  logic [3:0]  exp_ctrl;

  typedef struct {
    logic [10:0] op;
    logic [63:0] a, b, imm;
  } req_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [63:0] busb, res;
    logic        zero, taken, ill;
  } exp_t;

  typedef struct {
    req_t rq;
    exp_t ex;
  } vec_t;

  alu_issue_ctrl #(.SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .ResetL(ResetL), .InValid(InValid), .InReady(InReady),
    .Opcode(Opcode), .RegA(RegA), .RegB(RegB), .Imm(Imm),
    .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .BusW(BusW), .Zero(Zero),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
    .ZeroOut(ZeroOut), .BranchTaken(BranchTaken), .IllegalOp(IllegalOp)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU fed by the controller's registered buses.
  always_comb begin
    case (ALUCtrl)
      4'd0:    BusW = BusA & BusB;
      4'd1:    BusW = BusA | BusB;
      4'd2:    BusW = BusA + BusB;
      4'd6:    BusW = BusA - BusB;
      4'd7:    BusW = BusB;
      default: BusW = 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
    Zero = (BusW == 64'd0);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: instruction semantics straight from the opcode table.
  function automatic exp_t ref_model(input req_t r);
    exp_t e;
    logic [63:0] bv;
    logic use_imm, cbz, br;
    e = '{ctrl: 4'd0, busb: 64'd0, res: 64'd0, zero: 1'b0, taken: 1'b0, ill: 1'b0};
    use_imm = 1'b0; cbz = 1'b0; br = 1'b0;
    if      (r.op == 11'b10001011000) e.ctrl = 4'd2;
    else if (r.op == 11'b11001011000) e.ctrl = 4'd6;
    else if (r.op == 11'b10001010000) e.ctrl = 4'd0;
    else if (r.op == 11'b10101010000) e.ctrl = 4'd1;
    else if (r.op == 11'b11111000010 || r.op == 11'b11111000000) begin e.ctrl = 4'd2; use_imm = 1'b1; end
    else if (r.op ==? 11'b10110100???) begin e.ctrl = 4'd7; cbz = 1'b1; end
    else if (r.op ==? 11'b000101?????) begin e.ctrl = 4'd7; use_imm = 1'b1; br = 1'b1; end
    else if (r.op ==? 11'b110100101??) begin e.ctrl = 4'd7; use_imm = 1'b1; end
    else e.ill = 1'b1;
    if (e.ill) return e;
    bv = use_imm ? r.imm : r.b;
    e.busb = bv;
    case (e.ctrl)
      4'd0:    e.res = r.a & bv;
      4'd1:    e.res = r.a | bv;
      4'd2:    e.res = r.a + bv;
      4'd6:    e.res = r.a - bv;
      default: e.res = bv;
    endcase
    e.zero  = (e.res == 64'd0);
    e.taken = (cbz && e.zero) || br;
    return e;
  endfunction

  function automatic vec_t mk(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] imm, input logic [3:0] ctrl, input logic [63:0] busb,
                              input logic [63:0] res, input logic z, input logic t, input logic il);
    vec_t v;
    v.rq = '{op: op, a: a, b: b, imm: imm};
    v.ex = '{ctrl: ctrl, busb: busb, res: res, zero: z, taken: t, ill: il};
    return v;
  endfunction

  // Entered and left on a negedge; hold = cycles OutReady stays low in HOLD.
  task automatic run_op(input req_t r, input exp_t e, input int hold, input string tag);
    int to, lat;
    to = 0;
    while (!InReady && to < 50) begin @(posedge CLK); @(negedge CLK); to++; end
    check({tag, " ready_before_issue"}, 64'(InReady), 64'd1);
    Opcode = r.op; RegA = r.a; RegB = r.b; Imm = r.imm;
    InValid = 1'b1; OutReady = (hold == 0);
    @(posedge CLK); @(negedge CLK);
    InValid = 1'b0;
    Opcode = 11'($urandom); RegA = {$urandom, $urandom}; RegB = {$urandom, $urandom}; Imm = {$urandom, $urandom};
    if (!e.ill) begin exp_busa = r.a; exp_busb = e.busb; exp_ctrl = e.ctrl; end
    check({tag, " inready_busy"}, 64'(InReady), 64'd0);
    lat = 0;
    while (!OutValid && lat < 40) begin @(posedge CLK); @(negedge CLK); lat++; end
    check({tag, " latency"}, 64'(lat), e.ill ? 64'd1 : 64'(S));
    check({tag, " BusA"}, BusA, exp_busa);
    check({tag, " BusB"}, BusB, exp_busb);
    check({tag, " ALUCtrl"}, 64'(ALUCtrl), 64'(exp_ctrl));
    check({tag, " Result"}, Result, e.res);
    check({tag, " ZeroOut"}, 64'(ZeroOut), 64'(e.zero));
    check({tag, " BranchTaken"}, 64'(BranchTaken), 64'(e.taken));
    check({tag, " IllegalOp"}, 64'(IllegalOp), 64'(e.ill));
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); @(negedge CLK);
      check({tag, " stall OutValid"}, 64'(OutValid), 64'd1);
      check({tag, " stall Result"}, Result, e.res);
      check({tag, " stall ZeroOut"}, 64'(ZeroOut), 64'(e.zero));
      check({tag, " stall InReady"}, 64'(InReady), 64'd0);
    end
    OutReady = 1'b1;
    @(posedge CLK); @(negedge CLK);
    OutReady = 1'b0;
    check({tag, " post_hs OutValid"}, 64'(OutValid), 64'd0);
    check({tag, " post_hs InReady"}, 64'(InReady), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    req_t r;
    exp_t e;
    logic saw_valid;

    ResetL = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Opcode = '0; RegA = '0; RegB = '0; Imm = '0;
    exp_busa = '0; exp_busb = '0; exp_ctrl = '0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset InReady", 64'(InReady), 64'd0);
    check("reset OutValid", 64'(OutValid), 64'd0);
    check("reset BusA", BusA, 64'd0);
    check("reset BusB", BusB, 64'd0);
    check("reset ALUCtrl", 64'(ALUCtrl), 64'd0);
    check("reset Result", Result, 64'd0);
    check("reset flags", {61'd0, ZeroOut, BranchTaken, IllegalOp}, 64'd0);
    ResetL = 1'b1;
    @(posedge CLK); @(negedge CLK);

    vecs.push_back(mk(11'b10001011000, 64'd5, 64'd7, 64'd0, 4'd2, 64'd7, 64'd12, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(11'b10110100101, 64'd9, 64'd0, 64'd0, 4'd7, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(11'b10110100011, 64'd9, 64'd3, 64'd0, 4'd7, 64'd3, 64'd3, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(11'b11111000010, 64'h100, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8, 4'd2,
                      64'hFFFF_FFFF_FFFF_FFF8, 64'hF8, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(11'b00000000000, 64'd1, 64'd2, 64'd3, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(11'b00010111111, 64'd1, 64'd2, 64'h40, 4'd7, 64'h40, 64'h40, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(11'b11010010101, 64'd1, 64'd2, 64'h1234, 4'd7, 64'h1234, 64'h1234, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(11'b10001010000, 64'hFF, 64'hF0F, 64'd0, 4'd0, 64'hF0F, 64'hF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(11'b11111000000, 64'h200, 64'd5, 64'd8, 4'd2, 64'd8, 64'h208, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(11'b11001011000, 64'd3, 64'd5, 64'd0, 4'd6, 64'd5,
                      64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0));

    foreach (vecs[i]) run_op(vecs[i].rq, vecs[i].ex, 0, $sformatf("vec%0d", i));

    // SUB 9-9 with the consumer stalled for five cycles.
    r = '{op: 11'b11001011000, a: 64'd9, b: 64'd9, imm: 64'd0};
    run_op(r, '{ctrl: 4'd6, busb: 64'd9, res: 64'd0, zero: 1'b1, taken: 1'b0, ill: 1'b0}, 5, "sub_stall");

    // Illegal op while stalled: buses must keep the previous legal op's values.
    r = '{op: 11'b01111111111, a: 64'hAA, b: 64'hBB, imm: 64'hCC};
    run_op(r, '{ctrl: 4'd0, busb: 64'd0, res: 64'd0, zero: 1'b0, taken: 1'b0, ill: 1'b1}, 2, "illegal_stall");

    // Reset for one edge in the middle of SETTLE discards the op.
    Opcode = 11'b10001011000; RegA = 64'd100; RegB = 64'd200; InValid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    InValid = 1'b0; ResetL = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("midreset InReady", 64'(InReady), 64'd0);
    check("midreset BusA", BusA, 64'd0);
    check("midreset BusB", BusB, 64'd0);
    check("midreset Result", Result, 64'd0);
    check("midreset flags", {60'd0, ALUCtrl}, 64'd0);
    ResetL = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (OutValid) saw_valid = 1'b1;
    end
    check("midreset no OutValid", 64'(saw_valid), 64'd0);
    exp_busa = '0; exp_busb = '0; exp_ctrl = '0;
    r = '{op: 11'b10101010000, a: 64'hF0, b: 64'h0F, imm: 64'd0};
    run_op(r, '{ctrl: 4'd1, busb: 64'h0F, res: 64'hFF, zero: 1'b0, taken: 1'b0, ill: 1'b0}, 0, "orr_after_reset");

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [10:0] ops[9];
      ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
              11'b11111000010, 11'b11111000000, 11'b10110100000, 11'b00010100000, 11'b11010010100};
      r.op = ($urandom_range(0, 9) == 9) ? 11'($urandom) : ops[$urandom_range(0, 8)];
      if (r.op == 11'b10110100000) r.op[2:0] = 3'($urandom);
      if (r.op == 11'b00010100000) r.op[4:0] = 5'($urandom);
      if (r.op == 11'b11010010100) r.op[1:0] = 2'($urandom);
      r.a   = {$urandom, $urandom};
      r.b   = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      r.imm = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) r.b = r.a;
      e = ref_model(r);
      run_op(r, e, $urandom_range(0, 3), $sformatf("rnd%0d op=%b", n, r.op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
